spad_line_buffer: RTL

SPAD_LINE_BUFFER -- requirements
Module: spad_line_buffer

---
 rtl/spad_line_buffer_pkg.sv | 16 +
 rtl/spad_line_buffer_fifo.sv | 66 ++++++
 rtl/spad_line_buffer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/spad_line_buffer_pkg.sv
// Shared network parameters and helpers for the scratchpad line buffer.
package spad_line_buffer_pkg;

  localparam int unsigned SPAD_NUM_LINES     = 5;
  localparam int unsigned SPAD_FEATURE_WIDTH = 16;
  localparam int unsigned SPAD_BUS_WIDTH     = 128;
  localparam int unsigned SPAD_DEPTH         = 16;

  // Logical-to-physical line index under the rotating base.
  function automatic int unsigned line_map(input int unsigned base,
                                           input int unsigned line,
                                           input int unsigned num_lines);
    return (base + line) % num_lines;
  endfunction

endpackage

// File: rtl/spad_line_buffer_fifo.sv
// One line: wide words in, features out lowest-first, with a synchronous clear.
module spad_line_fifo #(
  parameter int unsigned FEATURE_WIDTH = 16,
  parameter int unsigned BUS_WIDTH     = 128,
  parameter int unsigned DEPTH         = 16,
  localparam int unsigned RATIO        = BUS_WIDTH / FEATURE_WIDTH,
  localparam int unsigned LVW          = $clog2(DEPTH * RATIO + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [BUS_WIDTH-1:0]     wr_data,
  input  logic                     rd_en,
  output logic [FEATURE_WIDTH-1:0] head,
  output logic [LVW-1:0]           level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_word;
  logic [SW-1:0]        rd_sub;
  logic [BUS_WIDTH-1:0] head_word;

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_ptr] <= wr_data;
  end

  // Write pointer is word-granular, read pointer is word + feature offset.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr  <= '0;
      rd_word <= '0;
      rd_sub  <= '0;
      level   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        if (rd_sub == SW'(RATIO - 1)) begin
          rd_sub  <= '0;
          rd_word <= rd_word + AW'(1);
        end else begin
          rd_sub <= rd_sub + SW'(1);
        end
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LVW'(RATIO);
        2'b01:   level <= level - LVW'(1);
        2'b11:   level <= level + LVW'(RATIO) - LVW'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    head_word = mem[rd_word];
    head      = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (SW'(k) == rd_sub) head = head_word[k*FEATURE_WIDTH +: FEATURE_WIDTH];
    end
  end

endmodule

// File: rtl/spad_line_buffer.sv
// Rotating bank of line FIFOs with parallel or single-line feature readout.
module spad_line_buffer
  import spad_line_buffer_pkg::*;
#(
  parameter int unsigned NUM_LINES     = SPAD_NUM_LINES,
  parameter int unsigned FEATURE_WIDTH = SPAD_FEATURE_WIDTH,
  parameter int unsigned BUS_WIDTH     = SPAD_BUS_WIDTH,
  parameter int unsigned DEPTH         = SPAD_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               rot_en,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [$clog2(NUM_LINES)-1:0]       wr_line,
  input  logic [BUS_WIDTH-1:0]               wr_data,
  input  logic                               rd_mode,
  input  logic [$clog2(NUM_LINES)-1:0]       rd_line,
  input  logic                               rd_en,
  output logic                               rd_ready,
  output logic                               rd_valid,
  output logic [FEATURE_WIDTH*NUM_LINES-1:0] rd_data,
  output logic [NUM_LINES-1:0]               line_empty,
  output logic [NUM_LINES-1:0]               line_full,
  output logic                               group_empty,
  output logic                               group_full,
  output logic                               err_ovf,
  output logic                               err_udf
);

  localparam int unsigned LW    = $clog2(NUM_LINES);
  localparam int unsigned FW    = FEATURE_WIDTH;
  localparam int unsigned RATIO = BUS_WIDTH / FEATURE_WIDTH;
  localparam int unsigned TOTAL = DEPTH * RATIO;
  localparam int unsigned LVW   = $clog2(TOTAL + 1);

  logic [NUM_LINES-1:0] fifo_clr;
  logic [NUM_LINES-1:0] fifo_wr;
  logic [NUM_LINES-1:0] fifo_rd;
  logic [FW-1:0]        fifo_head  [NUM_LINES];
  logic [LVW-1:0]       fifo_level [NUM_LINES];
  logic [FW-1:0]        log_head   [NUM_LINES];
  logic [LW-1:0]        base;

  logic wr_line_ok, rd_line_ok;
  logic wr_sel_full, rd_sel_empty;
  logic rd_empty_cause;
  logic wr_acc, rd_acc;

  // Per-logical-line view of the physical FIFOs.
  always_comb begin
    for (int unsigned l = 0; l < NUM_LINES; l++) begin
      log_head[l]   = fifo_head[line_map(32'(base), l, NUM_LINES)];
      line_empty[l] = (fifo_level[line_map(32'(base), l, NUM_LINES)] == '0);
      line_full[l]  = (fifo_level[line_map(32'(base), l, NUM_LINES)] > LVW'(TOTAL - RATIO));
    end
  end

  // Handshake readiness and error causes.
  always_comb begin
    wr_line_ok   = (32'(wr_line) < NUM_LINES);
    rd_line_ok   = (32'(rd_line) < NUM_LINES);
    wr_sel_full  = 1'b0;
    rd_sel_empty = 1'b0;
    for (int unsigned l = 0; l < NUM_LINES; l++) begin
      if (LW'(l) == wr_line) wr_sel_full  = line_full[l];
      if (LW'(l) == rd_line) rd_sel_empty = line_empty[l];
    end
    group_empty    = |line_empty;
    group_full     = &line_full;
    wr_ready       = wr_line_ok && !wr_sel_full && !flush && !rot_en;
    rd_empty_cause = rd_mode ? (rd_line_ok && rd_sel_empty) : group_empty;
    rd_ready       = !flush && !rot_en &&
                     (rd_mode ? (rd_line_ok && !rd_sel_empty) : !group_empty);
    wr_acc         = wr_valid && wr_ready;
    rd_acc         = rd_en && rd_ready;
  end

  // Physical strobes; rotation clears the line leaving logical 0.
  always_comb begin
    for (int unsigned p = 0; p < NUM_LINES; p++) begin
      fifo_clr[p] = flush || (rot_en && (LW'(p) == base));
      fifo_wr[p]  = wr_acc && (p == line_map(32'(base), 32'(wr_line), NUM_LINES));
      fifo_rd[p]  = rd_acc && (!rd_mode || (p == line_map(32'(base), 32'(rd_line), NUM_LINES)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
    end else begin
      if (wr_valid && wr_line_ok && wr_sel_full) err_ovf <= 1'b1;
      if (rd_en && rd_empty_cause)               err_udf <= 1'b1;
      if (!flush && rot_en) begin
        base <= (base == LW'(NUM_LINES - 1)) ? '0 : base + LW'(1);
      end
      rd_valid <= rd_acc;
      if (rd_acc) begin
        for (int unsigned l = 0; l < NUM_LINES; l++) begin
          rd_data[l*FW +: FW] <= (!rd_mode || (LW'(l) == rd_line)) ? log_head[l] : '0;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_LINES; p++) begin : g_line
    spad_line_fifo #(
      .FEATURE_WIDTH (FEATURE_WIDTH),
      .BUS_WIDTH     (BUS_WIDTH),
      .DEPTH         (DEPTH)
    ) u_line (
      .clk     (clk),
      .rst     (rst),
      .clr     (fifo_clr[p]),
      .wr_en   (fifo_wr[p]),
      .wr_data (wr_data),
      .rd_en   (fifo_rd[p]),
      .head    (fifo_head[p]),
      .level   (fifo_level[p])
    );
  end

endmodule
